// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
// Optional pending-write scoreboard is enabled by REGFILE_SCOREBOARD_EN.
package regfile_pkg;

  localparam int unsigned DEF_NREAD  = 4;
  localparam int unsigned DEF_NWRITE = 2;
  localparam int unsigned DEF_DW     = 32;
  localparam int unsigned DEF_AW     = 5;

  // Register 0 is hardwired zero.
  localparam int unsigned REG_ZERO = 0;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: zero register, youngest-writer bypass, array data.
// With REGFILE_SCOREBOARD_EN also produces the pending flag for this port.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int unsigned NWRITE = DEF_NWRITE,
  parameter int unsigned DW     = DEF_DW,
  parameter int unsigned AW     = DEF_AW
) (
  input  logic [AW-1:0]        raddr,
  input  logic                 run,
  input  logic [NWRITE-1:0]    we,
  input  logic [NWRITE*AW-1:0] waddr,
  input  logic [NWRITE*DW-1:0] wdata,
  input  logic [DW-1:0]        arr_data,
  output logic [DW-1:0]        rdata_c
`ifdef REGFILE_SCOREBOARD_EN
  ,
  input  logic                 pend,
  output logic                 rpend_c
`endif
);

  // Ascending scan so the highest-index (youngest) matching writer wins.
  always_comb begin
    rdata_c = arr_data;
    for (int unsigned j = 0; j < NWRITE; j++) begin
      if (we[j] && (waddr[j*AW +: AW] == raddr)) begin
        rdata_c = wdata[j*DW +: DW];
      end
    end
    if (!run || (raddr == AW'(REG_ZERO))) begin
      rdata_c = '0;
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  // A same-cycle write to the register resolves the hazard through the bypass.
  always_comb begin
    rpend_c = pend;
    for (int unsigned j = 0; j < NWRITE; j++) begin
      if (run && we[j] && (waddr[j*AW +: AW] == raddr)) begin
        rpend_c = 1'b0;
      end
    end
  end
`endif

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with reset-time clear sweep, write priority and bypass.
// Define REGFILE_SCOREBOARD_EN to add the pending-write scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned NREAD  = DEF_NREAD,
  parameter int unsigned NWRITE = DEF_NWRITE,
  parameter int unsigned DW     = DEF_DW,
  parameter int unsigned AW     = DEF_AW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREAD*AW-1:0]  raddr,
  output logic [NREAD*DW-1:0]  rdata,
  input  logic [NWRITE-1:0]    we,
  input  logic [NWRITE*AW-1:0] waddr,
  input  logic [NWRITE*DW-1:0] wdata,
  output logic                 ready
`ifdef REGFILE_SCOREBOARD_EN
  ,
  input  logic                 alloc_en,
  input  logic [AW-1:0]        alloc_addr,
  output logic [NREAD-1:0]     rpend
`endif
);

  localparam int unsigned   DEPTH = 2**AW;
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic          run_c;

  assign run_c = (state_q == ST_RUN);
  assign ready = ready_q;

  // Sweep control: entry 0 is never stored, so the sweep starts at 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + AW'(1);
      if (cnt_q == LAST) begin
        state_d = ST_RUN;
        ready_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= AW'(1);
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Array update: later ports overwrite earlier ones on an address conflict.
  always_comb begin
    mem_d = mem_q;
    if (!rst) begin
      if (state_q == ST_CLEAR) begin
        mem_d[cnt_q] = '0;
      end else begin
        for (int unsigned j = 0; j < NWRITE; j++) begin
          if (we[j] && (waddr[j*AW +: AW] != AW'(REG_ZERO))) begin
            mem_d[waddr[j*AW +: AW]] = wdata[j*DW +: DW];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [DEPTH-1:0] pend_q, pend_d;

  // Writeback clears, allocation sets; a new producer outranks a retiring one.
  always_comb begin
    pend_d = pend_q;
    if (state_q == ST_RUN) begin
      for (int unsigned j = 0; j < NWRITE; j++) begin
        if (we[j] && (waddr[j*AW +: AW] != AW'(REG_ZERO))) begin
          pend_d[waddr[j*AW +: AW]] = 1'b0;
        end
      end
      if (alloc_en && (alloc_addr != AW'(REG_ZERO))) begin
        pend_d[alloc_addr] = 1'b1;
      end
    end else begin
      pend_d = '0;
    end
    pend_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end
`endif

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = raddr[i*AW +: AW];

    regfile_rd_port #(
      .NWRITE (NWRITE),
      .DW     (DW),
      .AW     (AW)
    ) u_rd (
      .raddr    (ra),
      .run      (run_c),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .arr_data (mem_q[ra]),
      .rdata_c  (rdata[i*DW +: DW])
`ifdef REGFILE_SCOREBOARD_EN
      ,
      .pend     (pend_q[ra]),
      .rpend_c  (rpend[i])
`endif
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized self-checking bench for regfile_mp against a register-level reference model.
// Scoreboard checks are compiled in when REGFILE_SCOREBOARD_EN is defined.
module tb_regfile_mp;

  localparam int NR    = 4;
  localparam int NW    = 2;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR*AW-1:0]  raddr;
  logic [NR*DW-1:0]  rdata;
  logic [NW-1:0]     we;
  logic [NW*AW-1:0]  waddr;
  logic [NW*DW-1:0]  wdata;
  logic              ready;
`ifdef REGFILE_SCOREBOARD_EN
  logic              alloc_en;
  logic [AW-1:0]     alloc_addr;
  logic [NR-1:0]     rpend;
`endif

  always #5 clk = ~clk;

  regfile_mp #(.NREAD(NR), .NWRITE(NW), .DW(DW), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .raddr      (raddr),
    .rdata      (rdata),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .ready      (ready)
`ifdef REGFILE_SCOREBOARD_EN
    ,
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .rpend      (rpend)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: register values, run flag, post-reset edge count, pending bits.
  logic [DW-1:0] m_regs [DEPTH];
  bit            m_pend [DEPTH];
  bit            m_run;
  int            m_edges;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit hit(input int a);
    for (int j = 0; j < NW; j++)
      if (we[j] && int'(waddr[j*AW +: AW]) == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DW-1:0] exp_read(input int a);
    logic [DW-1:0] v;
    if (!m_run || a == 0) return '0;
    v = m_regs[a];
    for (int j = 0; j < NW; j++)
      if (we[j] && int'(waddr[j*AW +: AW]) == a) v = wdata[j*DW +: DW];
    return v;
  endfunction

  function automatic logic [DW-1:0] rd(input int i);
    return rdata[i*DW +: DW];
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_run   = 1'b0;
      m_edges = 0;
      for (int a = 0; a < DEPTH; a++) m_pend[a] = 1'b0;
    end else if (!m_run) begin
      m_edges++;
      if (m_edges == DEPTH - 1) begin
        m_run = 1'b1;
        for (int a = 0; a < DEPTH; a++) m_regs[a] = '0;
      end
    end else begin
      for (int j = 0; j < NW; j++) begin
        int a;
        a = int'(waddr[j*AW +: AW]);
        if (we[j] && a != 0) begin
          m_regs[a] = wdata[j*DW +: DW];
          m_pend[a] = 1'b0;
        end
      end
`ifdef REGFILE_SCOREBOARD_EN
      if (alloc_en && alloc_addr != 0) m_pend[int'(alloc_addr)] = 1'b1;
`endif
    end
  endtask

  task automatic check_all();
    chk("ready", {31'd0, ready}, {31'd0, m_run});
    for (int i = 0; i < NR; i++) begin
      int a;
      a = int'(raddr[i*AW +: AW]);
      chk($sformatf("rdata%0d_r%0d", i, a), rd(i), exp_read(a));
`ifdef REGFILE_SCOREBOARD_EN
      chk($sformatf("rpend%0d_r%0d", i, a), {31'd0, rpend[i]},
          {31'd0, (m_run && m_pend[a] && !hit(a))});
`endif
    end
  endtask

  // Check outputs for the current inputs, then clock once and advance the model.
  task automatic step();
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    we = '0;
`ifdef REGFILE_SCOREBOARD_EN
    alloc_en = 1'b0;
`endif
  endtask

  task automatic set_rd(input int i, input int a);
    raddr[i*AW +: AW] = AW'(a);
  endtask

  task automatic set_wr(input int j, input bit en, input int a, input logic [DW-1:0] d);
    we[j]             = en;
    waddr[j*AW +: AW] = AW'(a);
    wdata[j*DW +: DW] = d;
  endtask

  task automatic rand_writes();
    for (int j = 0; j < NW; j++)
      set_wr(j, 1'($urandom_range(0, 1)), $urandom_range(1, DEPTH - 1), $urandom);
  endtask

  initial begin
    int wa;
    rst = 1'b1; raddr = '0; waddr = '0; wdata = '0;
    idle();
`ifdef REGFILE_SCOREBOARD_EN
    alloc_addr = '0;
`endif
    @(posedge clk);
    model_edge();
    #1;
    rst = 1'b0;

    // Clear sweep timing and all-zero contents afterwards
    for (int k = 0; k < DEPTH - 2; k++) step();
    chk("ready_before_sweep_end", {31'd0, ready}, 32'd0);
    step();
    chk("ready_at_sweep_end", {31'd0, ready}, 32'd1);
    for (int g = 0; g < DEPTH / NR; g++) begin
      for (int i = 0; i < NR; i++) set_rd(i, g * NR + i);
      #1;
      for (int i = 0; i < NR; i++) chk("swept_zero", rd(i), 32'd0);
      step();
    end

    // Same-cycle bypass, then stored value
    set_wr(0, 1'b1, 3, 32'hDEADBEEF); set_rd(0, 3);
    #1 chk("bypass_r3", rd(0), 32'hDEADBEEF);
    step(); idle();
    #1 chk("stored_r3", rd(0), 32'hDEADBEEF);
    step();

    // Conflicting writes: higher port wins for both bypass and storage
    set_wr(0, 1'b1, 7, 32'h11); set_wr(1, 1'b1, 7, 32'h22); set_rd(1, 7);
    #1 chk("conflict_bypass_r7", rd(1), 32'h22);
    step(); idle();
    #1 chk("conflict_stored_r7", rd(1), 32'h22);
    step();

    // Writes to r0 are dropped
    set_wr(0, 1'b1, 0, 32'hFFFF_FFFF); set_rd(2, 0);
    #1 chk("r0_same_cycle", rd(2), 32'd0);
    step(); idle();
    #1 chk("r0_after", rd(2), 32'd0);
    step();

    // Reset mid-sweep restarts it; writes during the sweep are lost
    rst = 1'b1; step(); rst = 1'b0;
    wa = 9;
    for (int k = 0; k < 10; k++) begin rand_writes(); set_wr(0, 1'b1, wa, 32'hA5A5_0000 + k); step(); end
    rst = 1'b1; step(); rst = 1'b0;
    for (int k = 0; k < DEPTH - 2; k++) begin rand_writes(); set_wr(0, 1'b1, wa, 32'h5A5A_0000 + k); step(); end
    chk("ready_restart_low", {31'd0, ready}, 32'd0);
    rand_writes(); step(); idle();
    chk("ready_restart_high", {31'd0, ready}, 32'd1);
    set_rd(0, wa);
    #1 chk("clear_write_lost", rd(0), 32'd0);
    step();

`ifdef REGFILE_SCOREBOARD_EN
    // Scoreboard: allocate, resolve by bypass, and allocate over a retiring write
    alloc_en = 1'b1; alloc_addr = 5; step(); idle();
    set_rd(3, 5);
    #1 chk("rpend_alloc", {31'd0, rpend[3]}, 32'd1);
    step();
    set_wr(0, 1'b1, 5, 32'h55);
    #1 chk("rpend_bypass", {31'd0, rpend[3]}, 32'd0);
    chk("rdata_bypass_r5", rd(3), 32'h55);
    step(); idle();
    #1 chk("rpend_cleared", {31'd0, rpend[3]}, 32'd0);
    step();
    alloc_en = 1'b1; alloc_addr = 5; set_wr(1, 1'b1, 5, 32'h66); step(); idle();
    #1 chk("rpend_realloc", {31'd0, rpend[3]}, 32'd1);
    step();
`endif

    // Randomized traffic with conflicts, r0 hits and occasional resets
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 249) == 0);
      for (int j = 0; j < NW; j++)
        set_wr(j, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7)
                                                                        : $urandom_range(0, DEPTH - 1), $urandom);
      for (int i = 0; i < NR; i++) begin
        if ($urandom_range(0, 2) == 0) set_rd(i, int'(waddr[$urandom_range(0, NW - 1)*AW +: AW]));
        else set_rd(i, $urandom_range(0, DEPTH - 1));
      end
`ifdef REGFILE_SCOREBOARD_EN
      alloc_en   = ($urandom_range(0, 3) == 0);
      alloc_addr = AW'($urandom_range(0, DEPTH - 1));
`endif
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
